// File: rtl/hex_readback_pkg.sv
// Shared constants for the 7-segment readback path: active-low segment
// patterns (same values the encoder side drives) and the frame FSM states.
package hex_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] HEX_BLANK_NIBBLE = 4'hF;

  typedef enum logic [0:0] {
    FRAME_IDLE    = 1'b0,
    FRAME_PENDING = 1'b1
  } frame_state_t;

endpackage

// File: rtl/hex_readback_if.sv
// Frame delivery bus: decoded display frame offered with valid/ready.
interface hex_readback_if #(
  parameter int NUM_DIGITS = 6
);
  logic                    frame_valid;
  logic                    frame_ready;
  logic [4*NUM_DIGITS-1:0] frame_digits;
  logic [NUM_DIGITS-1:0]   frame_blank;
  logic [NUM_DIGITS-1:0]   frame_error;

  modport master (
    output frame_valid, frame_digits, frame_blank, frame_error,
    input  frame_ready
  );

  modport slave (
    input  frame_valid, frame_digits, frame_blank, frame_error,
    output frame_ready
  );
endinterface

// File: rtl/hex_readback_seg_decode.sv
// Inverse of the digit-to-segment encoder: exact-match decode of one
// active-low 7-segment pattern into a nibble plus blank/error flags.
module seg_decode
  import hex_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       blank_o,
  output logic       error_o
);

  // Exact pattern match; anything unrecognised is flagged as an error.
  always_comb begin
    nibble_o = HEX_BLANK_NIBBLE;
    blank_o  = 1'b0;
    error_o  = 1'b0;
    case (seg_i)
      SEG_0:     nibble_o = 4'h0;
      SEG_1:     nibble_o = 4'h1;
      SEG_2:     nibble_o = 4'h2;
      SEG_3:     nibble_o = 4'h3;
      SEG_4:     nibble_o = 4'h4;
      SEG_5:     nibble_o = 4'h5;
      SEG_6:     nibble_o = 4'h6;
      SEG_7:     nibble_o = 4'h7;
      SEG_8:     nibble_o = 4'h8;
      SEG_9:     nibble_o = 4'h9;
      SEG_BLANK: blank_o  = 1'b1;
      default:   error_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/hex_readback.sv
// Sequential 7-segment readback: scans one digit bus per clock, waits for
// each raw pattern to be stable, decodes it and hands out whole frames.
// A frame is only emitted when it differs from the last delivered one.
module hex_readback
  import hex_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int STABLE_SCANS = 4
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7*NUM_DIGITS-1:0] segments_in,
  hex_readback_if.master          frm
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (STABLE_SCANS > 0) ? $clog2(STABLE_SCANS + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_SCANS);

  logic [IDX_W-1:0]        idx_q;
  logic [6:0]              last_q [NUM_DIGITS];
  logic [3:0]              nib_q  [NUM_DIGITS];
  logic [CNT_W-1:0]        cnt_q  [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [NUM_DIGITS-1:0]   err_q;

  frame_state_t            state_q;
  logic                    frame_valid_q;
  logic                    delivered_q;
  logic [4*NUM_DIGITS-1:0] frame_digits_q;
  logic [NUM_DIGITS-1:0]   frame_blank_q;
  logic [NUM_DIGITS-1:0]   frame_error_q;

  logic [6:0]              seg_sel;
  logic [3:0]              dec_nib;
  logic                    dec_blank;
  logic                    dec_err;
  logic [4*NUM_DIGITS-1:0] cand_digits;
  logic                    all_stable;
  logic                    cand_changed;

  // Only the digit currently being visited goes through the decoder.
  assign seg_sel = segments_in[7*int'(idx_q) +: 7];

  seg_decode u_seg_decode (
    .seg_i    (seg_sel),
    .nibble_o (dec_nib),
    .blank_o  (dec_blank),
    .error_o  (dec_err)
  );

  // Scan pointer walks every digit in turn, independent of the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else if (idx_q == IDX_LAST) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_q + IDX_W'(1);
    end
  end

  // Per-digit tracking: a repeated pattern builds confidence, a new one restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        last_q[k]  <= SEG_BLANK;
        nib_q[k]   <= HEX_BLANK_NIBBLE;
        blank_q[k] <= 1'b1;
        err_q[k]   <= 1'b0;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx_q == IDX_W'(k)) begin
          if (seg_sel == last_q[k]) begin
            if (cnt_q[k] != CNT_MAX) begin
              cnt_q[k] <= cnt_q[k] + CNT_W'(1);
            end
          end else begin
            last_q[k]  <= seg_sel;
            nib_q[k]   <= dec_nib;
            blank_q[k] <= dec_blank;
            err_q[k]   <= dec_err;
            cnt_q[k]   <= '0;
          end
        end
      end
    end
  end

  // Candidate frame from registered digit state, and whether it is new.
  always_comb begin
    cand_digits = '0;
    all_stable  = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      cand_digits[4*k +: 4] = nib_q[k];
      all_stable            = all_stable & (cnt_q[k] == CNT_MAX);
    end
    cand_changed = (cand_digits != frame_digits_q) ||
                   (blank_q     != frame_blank_q)  ||
                   (err_q       != frame_error_q);
  end

  // Frame FSM; after acceptance the frame registers double as delivery history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FRAME_IDLE;
      frame_valid_q  <= 1'b0;
      delivered_q    <= 1'b0;
      frame_digits_q <= {NUM_DIGITS{HEX_BLANK_NIBBLE}};
      frame_blank_q  <= '1;
      frame_error_q  <= '0;
    end else begin
      case (state_q)
        FRAME_IDLE: begin
          if ((idx_q == '0) && all_stable && (!delivered_q || cand_changed)) begin
            frame_digits_q <= cand_digits;
            frame_blank_q  <= blank_q;
            frame_error_q  <= err_q;
            frame_valid_q  <= 1'b1;
            state_q        <= FRAME_PENDING;
          end
        end
        FRAME_PENDING: begin
          if (frm.frame_ready) begin
            frame_valid_q <= 1'b0;
            delivered_q   <= 1'b1;
            state_q       <= FRAME_IDLE;
          end
        end
        default: begin
          frame_valid_q <= 1'b0;
          state_q       <= FRAME_IDLE;
        end
      endcase
    end
  end

  assign frm.frame_valid  = frame_valid_q;
  assign frm.frame_digits = frame_digits_q;
  assign frm.frame_blank  = frame_blank_q;
  assign frm.frame_error  = frame_error_q;

endmodule

// File: tb/tb_hex_readback.sv
// Scoreboard bench for hex_readback: stimulus pushes expected frames, a
// monitor pops and compares them whenever a frame is accepted.
module tb_hex_readback;

  localparam int N = 6;

  localparam logic [7*N-1:0] SEGS_012345 = {7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  localparam logic [7*N-1:0] SEGS_ERRBLK = {7'h12, 7'h7F, 7'h7E, 7'h24, 7'h79, 7'h40};
  localparam logic [7*N-1:0] SEGS_ALL8   = {(7*N){1'b0}};

  typedef struct {
    logic [4*N-1:0] digits;
    logic [N-1:0]   blank;
    logic [N-1:0]   err;
    int             rise;   // >=0: exact valid-rise cycle, -2: rise one after an idx==0 cycle
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7*N-1:0] segments = SEGS_012345;
  int             cyc;
  int             checks = 0;
  int             errors = 0;
  exp_t           sb[$];
  logic           prev_v;
  logic           drop_chk;
  int             rise_c;

  hex_readback_if #(.NUM_DIGITS(N)) bus_a ();
  hex_readback_if #(.NUM_DIGITS(N)) bus_b ();

  hex_readback #(.NUM_DIGITS(N), .STABLE_SCANS(4)) dut_a (
    .clk(clk), .rst(rst), .segments_in(segments), .frm(bus_a)
  );

  hex_readback #(.NUM_DIGITS(N), .STABLE_SCANS(1)) dut_b (
    .clk(clk), .rst(rst), .segments_in(segments), .frm(bus_b)
  );

  always #5 clk = ~clk;

  // Cycle number relative to the most recent reset release.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4*N-1:0] d, input logic [N-1:0] b, input logic [N-1:0] e, input int r);
    exp_t x;
    x.digits = d; x.blank = b; x.err = e; x.rise = r;
    sb.push_back(x);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},  64'(bus_a.frame_valid),  64'd0);
    chk({tag, "_digits"}, 64'(bus_a.frame_digits), 64'hFFFFFF);
    chk({tag, "_blank"},  64'(bus_a.frame_blank),  64'h3F);
    chk({tag, "_error"},  64'(bus_a.frame_error),  64'h0);
  endtask

  initial begin
    bus_a.frame_ready = 1'b0;
    bus_b.frame_ready = 1'b0;

    fork
      // Monitor: compares each accepted frame against the scoreboard head.
      forever begin
        @(negedge clk);
        if (rst) begin
          prev_v   = 1'b0;
          drop_chk = 1'b0;
          rise_c   = -1;
        end else begin
          if (drop_chk) begin
            chk("valid_drop_after_accept", 64'(bus_a.frame_valid), 64'd0);
            drop_chk = 1'b0;
          end
          if (bus_a.frame_valid && !prev_v) rise_c = cyc;
          if (bus_a.frame_valid && bus_a.frame_ready) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_frame actual=%0h required=none (t=%0t)",
                       bus_a.frame_digits, $time);
            end else begin
              exp_t e;
              e = sb.pop_front();
              chk("frame_digits", 64'(bus_a.frame_digits), 64'(e.digits));
              chk("frame_blank",  64'(bus_a.frame_blank),  64'(e.blank));
              chk("frame_error",  64'(bus_a.frame_error),  64'(e.err));
              if (e.rise >= 0) chk("valid_rise_cycle", 64'(rise_c), 64'(e.rise));
              else             chk("valid_rise_phase", 64'(rise_c % N), 64'd1);
            end
            drop_chk = 1'b1;
          end
          prev_v = bus_a.frame_valid;
        end
      end
    join_none

    // Reset state
    repeat (3) tick();
    chk_reset_outputs("reset");

    // Static 0 1 2 3 4 5 from cycle 0, always ready
    push(24'h543210, 6'h00, 6'h00, 31);
    bus_a.frame_ready = 1'b1;
    rst = 1'b0;
    while (cyc < 12) tick();
    chk("ss1_valid_c12", 64'(bus_b.frame_valid), 64'd0);
    tick();
    chk("ss1_valid_c13", 64'(bus_b.frame_valid), 64'd1);
    chk("ss1_digits_c13", 64'(bus_b.frame_digits), 64'h543210);
    drain("first_frame_timeout", 100);
    repeat (60) tick();
    chk("no_refire_static", 64'(bus_a.frame_valid), 64'd0);

    // One-visit glitch on digit 2 must not produce a frame
    while ((cyc % N) != 2) tick();
    segments[20:14] = 7'h00;
    tick();
    segments[20:14] = 7'h24;
    repeat (72) tick();
    chk("no_frame_after_glitch", 64'(bus_a.frame_valid), 64'd0);

    // Reset clears history; then reset while pending
    bus_a.frame_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk_reset_outputs("rst_idle");
    rst = 1'b0;
    while (cyc < 30) tick();
    chk("pend_valid_c30", 64'(bus_a.frame_valid), 64'd0);
    tick();
    chk("pend_valid_c31", 64'(bus_a.frame_valid), 64'd1);
    rst = 1'b1;
    tick();
    chk_reset_outputs("rst_pending");
    rst = 1'b0;
    push(24'h543210, 6'h00, 6'h00, 31);
    while (cyc < 31) tick();
    chk("reemit_valid_c31", 64'(bus_a.frame_valid), 64'd1);

    // Held frame under backpressure while inputs move to all eights
    segments = SEGS_ALL8;
    repeat (80) tick();
    chk("held_valid", 64'(bus_a.frame_valid), 64'd1);
    chk("held_digits", 64'(bus_a.frame_digits), 64'h543210);
    push(24'h888888, 6'h00, 6'h00, -2);
    bus_a.frame_ready = 1'b1;
    drain("eights_timeout", 100);

    // Error on digit 3, blank on digit 4
    segments = SEGS_ERRBLK;
    push(24'h5FF210, 6'b010000, 6'b001000, -2);
    drain("errblank_timeout", 100);

    // Back to all eights: A, B, A sequence re-emits A
    segments = SEGS_ALL8;
    push(24'h888888, 6'h00, 6'h00, -2);
    drain("aba_timeout", 100);
    repeat (40) tick();
    chk("final_idle", 64'(bus_a.frame_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_readback.md
# hex_readback

Sequential 7-segment readback decoder: the inverse of the board's digit-to-segment encoding. Scans a bank of active-low 7-segment buses one digit per clock, requires each raw pattern to be stable before trusting it, decodes it back to a 4-bit digit with blank/error flags, and delivers complete display frames over a valid/ready handshake. Sits beside the display drivers in `game_play` for self-check of the clock/score displays and for bench scoreboarding.

## Interface
- `NUM_DIGITS`, 6: number of 7-segment buses scanned (HEX0..HEX5).
- `STABLE_SCANS`, 4: consecutive identical visits required before a digit counts as stable; must be ≥1.
- `clk`  in  1: sole clock.
- `rst`  in  1: reset, synchronous and active-high.
- `segments_in`  in  7*NUM_DIGITS: digit k on bits [7k+6:7k], active-low (0 = segment lit).
- `frame_valid`  out  1: frame registers hold an undelivered frame.
- `frame_ready`  in  1: consumer accepts when high with `frame_valid`.
- `frame_digits`  out  4*NUM_DIGITS: decoded digit k on [4k+3:4k].
- `frame_blank`  out  NUM_DIGITS: digit k was all-off.
- `frame_error`  out  NUM_DIGITS: digit k was a pattern outside the decode set.

## Operation
- Scan index `idx` counts 0..NUM_DIGITS-1, wraps to 0, advances every cycle regardless of handshake.
- Each digit holds: last raw pattern (reset 7'h7F), decoded nibble/blank/error, saturating stability count (reset 0, width $clog2(STABLE_SCANS+1)).
- On the cycle `idx==k`: if `segments_in[k]` equals last pattern, count increments (saturates at STABLE_SCANS); otherwise last pattern and decoded fields load from the input and count clears to 0.
- Decode (exact match only): 7'h40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9. 7'h7F → digit 4'hF, blank=1. Any other pattern → digit 4'hF, error=1. Blank and error never both set.
- Digit stable ⇔ count == STABLE_SCANS (errors and blanks can be stable).
- Frame FSM, states IDLE and PENDING:
  - IDLE, cycle with `idx==0`: if all digits stable AND (no frame delivered since reset OR decoded digits/blank/error differ from last delivered frame), load frame registers from registered per-digit state → PENDING.
  - PENDING: frame registers and `frame_valid` held constant; on `frame_valid && frame_ready`, record frame as delivered → IDLE.
  - Candidate frames arising while PENDING are dropped; stability tracking continues. The IDLE check runs only on `idx==0` cycles, so a frame can load no earlier than the next `idx==0` after acceptance.
- Identical frames are never re-emitted; an A→B→A change sequence emits A, B, A.
- `rst` mid-operation: all state returns to reset values next cycle; pending frame discarded, "delivered" history cleared.

## Timing
- Reset values: `frame_valid`=0, `frame_digits`=all 4'hF, `frame_blank`=all 1, `frame_error`=0; `idx`=0, FSM IDLE.
- Cycle 0 = first cycle with `rst` low. Digit k is visited on cycles k, k+N, k+2N, … (N=NUM_DIGITS).
- Static input from cycle 0 (defaults): digit k stable after cycle k+24; first frame check passing at cycle 30; `frame_valid` high from cycle 31.
- General: new pattern first seen at visit v is stable after visit v+STABLE_SCANS; frame loads on the next `idx==0` cycle, `frame_valid` one cycle later.
- Glitch on a digit shorter than STABLE_SCANS visits resets its count and delays (never corrupts) the next frame.
- Acceptance is single-cycle: `frame_valid` drops the cycle after the handshake.

## Structure
- Package `hex_pkg`: `SEG_0`..`SEG_9`, `SEG_BLANK` localparams (active-low constants shared with the encoder side), `HEX_BLANK_NIBBLE`=4'hF, frame FSM enum `frame_state_t`.
- One sub-module `seg_decode`: combinational 7-bit → {nibble, blank, error}, instantiated once on the `idx`-muxed scan input.

## Test plan
- Static "0 1 2 3 4 5" (7'h40,79,24,30,19,12) from cycle 0, `frame_ready`=1 → `frame_valid` high exactly cycle 31, digits 0..5, blank=0, error=0; no second frame afterward.
- `frame_ready`=0, inputs changed to all 7'h00 after first frame → frame stays 0..5 and valid; raise ready → accepted, next frame all 8s on a subsequent `idx==0`+1 cycle.
- Digit 2 pulsed to 7'h00 for one cycle at its visit, then restored → no new frame emitted.
- Digit 3 = 7'h7E, digit 4 = 7'h7F → frame_error=6'b001000, frame_blank=6'b010000, both nibbles 4'hF.
- STABLE_SCANS=1, N=6 static input → `frame_valid` from cycle 13 (digit 5 stable after cycle 11, check at cycle 12).
- `rst` pulsed while PENDING → `frame_valid`=0 next cycle, outputs at reset values, identical input re-emitted at reset-relative cycle 31.
